// File: rtl/avmm_reg_sop_tracker.sv
// Registered Avalon-MM pipeline stage (output register + one skid entry) with a
// master-side write-burst SOP/EOP tracker and a one-cycle registered response path.
module avmm_reg_sop_tracker #(
    parameter int ADDR_WIDTH      = 42,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int RESPONSE_WIDTH  = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,

    input  logic                         m_read,
    input  logic                         m_write,
    input  logic [ADDR_WIDTH-1:0]        m_address,
    input  logic [BURST_CNT_WIDTH-1:0]   m_burstcount,
    input  logic [DATA_WIDTH-1:0]        m_writedata,
    input  logic [DATA_WIDTH/8-1:0]      m_byteenable,
    output logic                         m_waitrequest,
    output logic [DATA_WIDTH-1:0]        m_readdata,
    output logic                         m_readdatavalid,
    output logic [RESPONSE_WIDTH-1:0]    m_response,
    output logic                         m_writeresponsevalid,

    output logic                         s_read,
    output logic                         s_write,
    output logic [ADDR_WIDTH-1:0]        s_address,
    output logic [BURST_CNT_WIDTH-1:0]   s_burstcount,
    output logic [DATA_WIDTH-1:0]        s_writedata,
    output logic [DATA_WIDTH/8-1:0]      s_byteenable,
    input  logic                         s_waitrequest,
    input  logic [DATA_WIDTH-1:0]        s_readdata,
    input  logic                         s_readdatavalid,
    input  logic [RESPONSE_WIDTH-1:0]    s_response,
    input  logic                         s_writeresponsevalid,

    output logic                         wr_sop,
    output logic                         wr_eop
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                       out_read_q, out_write_q;
    logic [ADDR_WIDTH-1:0]      out_addr_q;
    logic [BURST_CNT_WIDTH-1:0] out_burst_q;
    logic [DATA_WIDTH-1:0]      out_data_q;
    logic [BE_WIDTH-1:0]        out_be_q;

    logic                       skid_valid_q, skid_read_q, skid_write_q;
    logic [ADDR_WIDTH-1:0]      skid_addr_q;
    logic [BURST_CNT_WIDTH-1:0] skid_burst_q;
    logic [DATA_WIDTH-1:0]      skid_data_q;
    logic [BE_WIDTH-1:0]        skid_be_q;

    logic                       rsp_rvalid_q, rsp_wvalid_q;
    logic [DATA_WIDTH-1:0]      rsp_data_q;
    logic [RESPONSE_WIDTH-1:0]  rsp_code_q;

    logic [BURST_CNT_WIDTH-1:0] rem_q, rem_d;
    logic                       out_read_d, out_write_d, skid_valid_d;

    logic accept, out_valid, out_adv, load_from_skid, load_from_m, load_skid;

    assign accept         = (m_read | m_write) & ~skid_valid_q;
    assign out_valid      = out_read_q | out_write_q;
    assign out_adv        = ~out_valid | ~s_waitrequest;
    assign load_from_skid = out_adv & skid_valid_q;
    // accept already implies an empty skid, so an advancing output register takes the new beat
    assign load_from_m    = out_adv & accept;
    assign load_skid      = accept & ~out_adv;

    always_comb begin
        out_read_d   = out_read_q;
        out_write_d  = out_write_q;
        skid_valid_d = skid_valid_q;
        if (load_from_skid) begin
            out_read_d   = skid_read_q;
            out_write_d  = skid_write_q;
            skid_valid_d = 1'b0;
        end else if (load_from_m) begin
            out_read_d  = m_read;
            out_write_d = m_write;
        end else if (out_adv) begin
            out_read_d  = 1'b0;
            out_write_d = 1'b0;
        end
        if (load_skid) begin
            skid_valid_d = 1'b1;
        end
    end

    assign wr_sop = (rem_q == '0);
    assign wr_eop = wr_sop ? (m_burstcount <= BURST_CNT_WIDTH'(1))
                           : (rem_q == BURST_CNT_WIDTH'(1));

    // A zero burstcount is treated as a single-beat burst, leaving rem at zero
    always_comb begin
        rem_d = rem_q;
        if (m_write && accept) begin
            if (wr_sop) begin
                rem_d = (m_burstcount == '0) ? '0 : m_burstcount - BURST_CNT_WIDTH'(1);
            end else begin
                rem_d = rem_q - BURST_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_read_q   <= 1'b0;
            out_write_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_read_q  <= 1'b0;
            skid_write_q <= 1'b0;
            rsp_rvalid_q <= 1'b0;
            rsp_wvalid_q <= 1'b0;
            rem_q        <= '0;
        end else begin
            out_read_q   <= out_read_d;
            out_write_q  <= out_write_d;
            skid_valid_q <= skid_valid_d;
            if (load_skid) begin
                skid_read_q  <= m_read;
                skid_write_q <= m_write;
            end
            rsp_rvalid_q <= s_readdatavalid;
            rsp_wvalid_q <= s_writeresponsevalid;
            rem_q        <= rem_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_from_skid) begin
            out_addr_q  <= skid_addr_q;
            out_burst_q <= skid_burst_q;
            out_data_q  <= skid_data_q;
            out_be_q    <= skid_be_q;
        end else if (load_from_m) begin
            out_addr_q  <= m_address;
            out_burst_q <= m_burstcount;
            out_data_q  <= m_writedata;
            out_be_q    <= m_byteenable;
        end
        if (load_skid) begin
            skid_addr_q  <= m_address;
            skid_burst_q <= m_burstcount;
            skid_data_q  <= m_writedata;
            skid_be_q    <= m_byteenable;
        end
        rsp_data_q <= s_readdata;
        rsp_code_q <= s_response;
    end

    assign m_waitrequest        = skid_valid_q;
    assign s_read               = out_read_q;
    assign s_write              = out_write_q;
    assign s_address            = out_addr_q;
    assign s_burstcount         = out_burst_q;
    assign s_writedata          = out_data_q;
    assign s_byteenable         = out_be_q;
    assign m_readdata           = rsp_data_q;
    assign m_readdatavalid      = rsp_rvalid_q;
    assign m_response           = rsp_code_q;
    assign m_writeresponsevalid = rsp_wvalid_q;

endmodule

// File: tb/tb_avmm_reg_sop_tracker.sv
// Directed bench for avmm_reg_sop_tracker: reads, write bursts, backpressure,
// stalled beats, degenerate/maximal burst lengths and mid-burst reset.
module tb_avmm_reg_sop_tracker;

    localparam int AW = 42;
    localparam int DW = 512;
    localparam int BW = 7;
    localparam int RW = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic m_read, m_write;
    logic [AW-1:0] m_address;
    logic [BW-1:0] m_burstcount;
    logic [DW-1:0] m_writedata;
    logic [DW/8-1:0] m_byteenable;
    logic m_waitrequest;
    logic [DW-1:0] m_readdata;
    logic m_readdatavalid;
    logic [RW-1:0] m_response;
    logic m_writeresponsevalid;
    logic s_read, s_write;
    logic [AW-1:0] s_address;
    logic [BW-1:0] s_burstcount;
    logic [DW-1:0] s_writedata;
    logic [DW/8-1:0] s_byteenable;
    logic s_waitrequest;
    logic [DW-1:0] s_readdata;
    logic s_readdatavalid;
    logic [RW-1:0] s_response;
    logic s_writeresponsevalid;
    logic wr_sop, wr_eop;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    avmm_reg_sop_tracker #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .RESPONSE_WIDTH(RW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m_read(m_read), .m_write(m_write), .m_address(m_address),
        .m_burstcount(m_burstcount), .m_writedata(m_writedata),
        .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .m_response(m_response), .m_writeresponsevalid(m_writeresponsevalid),
        .s_read(s_read), .s_write(s_write), .s_address(s_address),
        .s_burstcount(s_burstcount), .s_writedata(s_writedata),
        .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .s_response(s_response), .s_writeresponsevalid(s_writeresponsevalid),
        .wr_sop(wr_sop), .wr_eop(wr_eop)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic [AW-1:0] a, input logic [BW-1:0] bc, input logic [DW-1:0] d);
        m_read = 1'b0;
        m_write = 1'b1;
        m_address = a;
        m_burstcount = bc;
        m_writedata = d;
        m_byteenable = '1;
        #1;
    endtask

    task automatic idle();
        m_read = 1'b0;
        m_write = 1'b0;
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        m_read = 1'b0; m_write = 1'b0; m_address = '0; m_burstcount = '0;
        m_writedata = '0; m_byteenable = '0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
        s_response = '0; s_writeresponsevalid = 1'b0;
        tick(); tick();
        chk("rst_s_write", s_write, 0);
        chk("rst_s_read", s_read, 0);
        chk("rst_waitreq", m_waitrequest, 0);
        chk("rst_rdv", m_readdatavalid, 0);
        chk("rst_sop", wr_sop, 1);
        reset_n = 1'b1;
        tick();

        // single read and read response
        m_read = 1'b1; m_address = 42'h100; m_burstcount = 7'd1; #1;
        chk("rd_wait", m_waitrequest, 0);
        tick();
        chk("rd_s_read", s_read, 1);
        chk("rd_s_addr", s_address, 42'h100);
        m_read = 1'b0; s_readdatavalid = 1'b1; s_readdata = 512'hAB;
        tick();
        chk("rd_rdv", m_readdatavalid, 1);
        chk("rd_data", m_readdata, 512'hAB);
        chk("rd_s_read_done", s_read, 0);
        s_readdatavalid = 1'b0;
        tick();
        chk("rd_rdv_done", m_readdatavalid, 0);

        // 4-beat burst back-to-back
        for (int i = 0; i < 4; i++) begin
            drive_wr(42'h200 + 42'(i), 7'd4, 512'(i + 1));
            chk($sformatf("b4_sop%0d", i), wr_sop, (i == 0) ? 1 : 0);
            chk($sformatf("b4_eop%0d", i), wr_eop, (i == 3) ? 1 : 0);
            tick();
            chk($sformatf("b4_swr%0d", i), s_write, 1);
            chk($sformatf("b4_sdata%0d", i), s_writedata, 512'(i + 1));
            chk($sformatf("b4_saddr%0d", i), s_address, 42'h200 + 42'(i));
        end
        // 2-beat burst with a read slipped in between its beats
        drive_wr(42'h300, 7'd2, 512'h21);
        chk("b2_sop0", wr_sop, 1);
        chk("b2_eop0", wr_eop, 0);
        tick();
        m_write = 1'b0; m_read = 1'b1; m_address = 42'h400; #1;
        chk("mid_rd_sop", wr_sop, 0);
        tick();
        chk("mid_rd_s_read", s_read, 1);
        chk("mid_rd_s_addr", s_address, 42'h400);
        drive_wr(42'h301, 7'd2, 512'h22);
        chk("b2_sop1", wr_sop, 0);
        chk("b2_eop1", wr_eop, 1);
        tick();
        chk("b2_sdata1", s_writedata, 512'h22);
        chk("b2_s_read_clear", s_read, 0);

        // burstcount 1 and 0
        drive_wr(42'h500, 7'd1, 512'h31);
        chk("bc1_sop", wr_sop, 1);
        chk("bc1_eop", wr_eop, 1);
        tick();
        drive_wr(42'h501, 7'd0, 512'h32);
        chk("bc0_sop", wr_sop, 1);
        chk("bc0_eop", wr_eop, 1);
        tick();
        drive_wr(42'h502, 7'd1, 512'h33);
        chk("bc0_next_sop", wr_sop, 1);
        tick();
        idle();
        tick();
        chk("idle_s_write", s_write, 0);

        // backpressure with stalled beats
        s_waitrequest = 1'b1;
        drive_wr(42'h600, 7'd4, 512'h10);
        chk("bp_sop0", wr_sop, 1);
        chk("bp_wait0", m_waitrequest, 0);
        tick();
        drive_wr(42'h601, 7'd4, 512'h11);
        chk("bp_wait1", m_waitrequest, 0);
        chk("bp_sop1", wr_sop, 0);
        tick();
        chk("bp_sdata_hold", s_writedata, 512'h10);
        drive_wr(42'h602, 7'd4, 512'h12);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("bp_wait_hi%0d", i), m_waitrequest, 1);
            chk($sformatf("bp_stall_sop%0d", i), wr_sop, 0);
            chk($sformatf("bp_stall_eop%0d", i), wr_eop, 0);
            chk($sformatf("bp_sdata_stable%0d", i), s_writedata, 512'h10);
            chk($sformatf("bp_saddr_stable%0d", i), s_address, 42'h600);
            tick();
        end
        s_waitrequest = 1'b0; #1;
        tick();
        chk("bp_drain_data", s_writedata, 512'h11);
        chk("bp_wait_lo", m_waitrequest, 0);
        chk("bp_beat2_eop", wr_eop, 0);
        tick();
        chk("bp_beat2_data", s_writedata, 512'h12);
        drive_wr(42'h603, 7'd4, 512'h13);
        chk("bp_beat3_eop", wr_eop, 1);
        chk("bp_beat3_sop", wr_sop, 0);
        tick();
        chk("bp_beat3_data", s_writedata, 512'h13);
        idle();
        tick();
        chk("bp_done_s_write", s_write, 0);
        chk("bp_done_sop", wr_sop, 1);

        // 127-beat burst
        for (int i = 1; i <= 127; i++) begin
            drive_wr(42'h1000 + 42'(i), 7'd127, 512'(i));
            chk($sformatf("b127_sop%0d", i), wr_sop, (i == 1) ? 1 : 0);
            chk($sformatf("b127_eop%0d", i), wr_eop, (i == 127) ? 1 : 0);
            tick();
        end
        chk("b127_last_data", s_writedata, 512'd127);
        idle();
        tick();
        chk("b127_after_sop", wr_sop, 1);

        // reset in the middle of a burst with skid occupied and a response in flight
        s_waitrequest = 1'b1;
        drive_wr(42'h700, 7'd4, 512'h41);
        tick();
        drive_wr(42'h701, 7'd4, 512'h42);
        s_readdatavalid = 1'b1; s_readdata = 512'hCD; #1;
        tick();
        chk("mr_s_write", s_write, 1);
        chk("mr_wait", m_waitrequest, 1);
        chk("mr_rdv", m_readdatavalid, 1);
        chk("mr_sop_mid", wr_sop, 0);
        idle();
        s_readdatavalid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mr_rst_s_write", s_write, 0);
        chk("mr_rst_wait", m_waitrequest, 0);
        chk("mr_rst_rdv", m_readdatavalid, 0);
        chk("mr_rst_sop", wr_sop, 1);
        tick();
        reset_n = 1'b1;
        s_waitrequest = 1'b0;
        tick();
        drive_wr(42'h800, 7'd3, 512'h51);
        chk("mr_next_sop", wr_sop, 1);
        chk("mr_next_eop", wr_eop, 0);
        tick();
        chk("mr_next_data", s_writedata, 512'h51);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avmm_reg_sop_tracker.md
Name: avmm_reg_sop_tracker

Overview:
- One-stage registered Avalon-MM pipeline stage with a master-side write-burst SOP/EOP tracker.
- Sits between an AFU Avalon-MM master and a host-memory slave. Breaks timing on all request and response signals.
- Flags the first and last beat of each accepted write burst, so that handlers can capture the burst address only on SOP beats.

Parameters:
ADDR_WIDTH  42  line address width
DATA_WIDTH  512  data width; byteenable width is DATA_WIDTH/8
BURST_CNT_WIDTH  7  burstcount width
RESPONSE_WIDTH  2  response code width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
m_read  in  1  read request from master
m_write  in  1  write beat from master
m_address  in  ADDR_WIDTH  request address
m_burstcount  in  BURST_CNT_WIDTH  burst length in beats
m_writedata  in  DATA_WIDTH  write data
m_byteenable  in  DATA_WIDTH/8  byte enables
m_waitrequest  out  1  stall to master (registered)
m_readdata  out  DATA_WIDTH  read data to master
m_readdatavalid  out  1  read data valid
m_response  out  RESPONSE_WIDTH  response code
m_writeresponsevalid  out  1  write response valid
s_read, s_write, s_address, s_burstcount, s_writedata, s_byteenable  out  (as m_*)  registered request to slave
s_waitrequest  in  1  stall from slave
s_readdata, s_readdatavalid, s_response, s_writeresponsevalid  in  (as m_*)  responses from slave
wr_sop  out  1  current m_write beat is first beat of a burst
wr_eop  out  1  current m_write beat is last beat of a burst

Behaviour:
- Reset is asynchronous, active-low. While reset_n=0, all registered outputs are 0: s_read, s_write, m_readdatavalid, m_writeresponsevalid, m_waitrequest, skid/output-valid flags, and the burst counter. Data and address registers are don't-care but must not produce valid strobes. After reset, wr_sop=1.
- Request acceptance: a beat is accepted when (m_read|m_write) && !m_waitrequest.
- m_waitrequest is a register. It equals 1 exactly when the skid entry is occupied.
- Request datapath has two storage elements: an output register driving s_*, and a skid entry.
- The output register advances when it is empty or !s_waitrequest.
- An accepted beat goes to the output register if that register can advance and the skid is empty. Otherwise it goes to the skid entry.
- The skid drains into the output register first whenever the output register advances.
- Latency: minimum 1 cycle from acceptance to the beat appearing on s_*. Full throughput (1 beat/cycle) when s_waitrequest=0.
- s_* fields hold stable while s_waitrequest=1 and s_read|s_write=1.
- Beat order is preserved. No beat is dropped or duplicated.
- Response path: s_readdata, s_readdatavalid, s_response and s_writeresponsevalid are registered 1 cycle to m_*, with no backpressure.
- SOP tracker: tracks master-side accepted write beats (m_write && !m_waitrequest) using a counter rem of BURST_CNT_WIDTH bits.
- wr_sop = (rem==0), combinational from state. Valid whenever m_write=1.
- On an accepted SOP beat, rem <= m_burstcount-1. On an accepted non-SOP beat, rem <= rem-1.
- wr_eop = wr_sop ? (m_burstcount<=1) : (rem==1).
- m_burstcount=0 is illegal and is treated as 1: single-beat burst, sop=eop=1.
- Reads and stalled write beats do not change rem.
- A read accepted mid write-burst is passed through and does not disturb rem.
- Maximum burst is 2^BURST_CNT_WIDTH-1 beats. rem never wraps below 0.
- Reset mid-burst clears rem. The next write beat is an SOP.

Test Plan:
- Single reads with s_waitrequest=0: m_read at addr 0x100, burstcount 1 → s_read=1 with addr 0x100 one cycle later. s_readdatavalid with data 0xAB → m_readdatavalid with 0xAB one cycle later. m_waitrequest stays 0.
- Write burst of 4 beats back-to-back → wr_sop=1,0,0,0 and wr_eop=0,0,0,1. Next burstcount-2 burst → wr_sop=1,0 and wr_eop=0,1. All beats appear in order on s_*.
- Backpressure: hold s_waitrequest=1 while the master streams writes → exactly one beat enters the skid, then m_waitrequest=1 the following cycle. s_* is stable throughout. Release → all beats delivered, none lost, m_waitrequest returns to 0.
- Stalled beats: m_write asserted while m_waitrequest=1 → rem unchanged, wr_sop/wr_eop unchanged until the beat is accepted.
- burstcount=1 and burstcount=0 writes → wr_sop=1 and wr_eop=1 on each beat. 127-beat burst (width 7) → wr_eop only on beat 127.
- Assert reset_n=0 after beat 2 of a 4-beat burst → s_write, m_waitrequest and m_readdatavalid drop immediately. After release, the next write has wr_sop=1.
